// File: rtl/ram_resp_port.sv
`default_nettype none
// ============================================================================
// Module   : ram_resp_port
// Purpose  : req/gnt/rvalid RAM responder with byte-enable writes, grant stall
//            and one-cycle read response. Define RAM_RESP_RANDOM_STALL_EN to
//            draw a pseudo-random stall (0..GNT_STALL) per request.
// Revision : 1.0 - initial release
// ============================================================================
module ram_resp_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 1024,
  parameter int GNT_STALL  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int c_nb       = DATA_WIDTH / 8;
  localparam int c_addr_lsb = $clog2(c_nb);
  localparam int c_idx_w    = $clog2(NUM_WORDS);
  localparam int c_cnt_w    = $clog2(GNT_STALL + 2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_cnt_w-1:0]      r_cnt, w_cnt_nxt;
  logic [c_cnt_w-1:0]      w_stall;
  logic                    w_gnt;
  logic                    w_load;
  logic                    w_err_set;
  logic                    w_changed;
  logic                    r_rvalid;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [c_nb-1:0]         r_be;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_idx_w-1:0]      w_idx;
  logic [DATA_WIDTH-1:0]   r_mem [NUM_WORDS];

  assign w_idx = addr_i[c_addr_lsb +: c_idx_w];

`ifdef RAM_RESP_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = c_cnt_w'(32'(r_lfsr[7:0]) % (GNT_STALL + 1));
`else
  assign w_stall = c_cnt_w'(GNT_STALL);
`endif

  // Request fields must stay stable from stall start until grant
  assign w_changed = (addr_i != r_addr) || (we_i != r_we) ||
                     (be_i != r_be) || (wdata_i != r_wdata);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 1'b0;
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          if (w_stall == '0) begin
            w_gnt = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_cnt_nxt   = w_stall;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_i) begin
          w_err_set   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          if (w_changed) begin
            w_err_set = 1'b1;
          end
          if (r_cnt <= c_cnt_w'(1)) begin
            w_gnt       = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_w'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_gnt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_gnt && !we_i) begin
        r_rdata <= r_mem[w_idx];
      end
      if (w_load) begin
        r_addr  <= addr_i;
        r_we    <= we_i;
        r_be    <= be_i;
        r_wdata <= wdata_i;
      end
    end
  end

  // Storage has no reset; only the enabled byte lanes are written
  always_ff @(posedge clk) begin
    if (w_gnt && we_i) begin
      for (int b = 0; b < c_nb; b++) begin
        if (be_i[b]) begin
          r_mem[w_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign gnt_o    = w_gnt & rst_n;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule
`default_nettype wire
